// File: rtl/uram_line_loader_if.sv
// Stream-in / URAM-write-out bundle for uram_line_loader.
//   s_data/s_valid/s_last/s_ready : valid/ready word stream into the loader
//   mem_en/mem_wr_en/mem_address/mem_wr_data : URAM write port driven by the loader
// master = loader side, slave = stream source / memory side.
interface uram_line_loader_if #(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned AWIDTH = 8,
   parameter int unsigned LWIDTH = 64
);
   logic [DWIDTH-1:0] s_data;
   logic              s_valid;
   logic              s_last;
   logic              s_ready;
   logic              mem_en;
   logic              mem_wr_en;
   logic [AWIDTH-1:0] mem_address;
   logic [LWIDTH-1:0] mem_wr_data;

   modport master (
      input  s_data, s_valid, s_last,
      output s_ready,
      output mem_en, mem_wr_en, mem_address, mem_wr_data
   );

   modport slave (
      output s_data, s_valid, s_last,
      input  s_ready,
      input  mem_en, mem_wr_en, mem_address, mem_wr_data
   );
endinterface

// File: rtl/uram_line_loader.sv
// Packs a DWIDTH-bit valid/ready stream into LWIDTH-bit lines and writes each
// line to a URAM write port, starting at a line-aligned word address.
// Ports:
//   clock, reset_n : single clock, async active-low reset
//   start          : begin a load (honoured only when idle)
//   start_addr     : word address of the first line (low lane bits ignored)
//   bus (master)   : stream input + URAM write port
//   busy           : not idle
//   done           : one-cycle pulse at end of load
//   lines_written  : line writes issued in the current/last load
//   wrapped        : line pointer wrapped during the current/last load
module uram_line_loader #(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned AWIDTH = 8,
   parameter int unsigned LWIDTH = 64
) (
   input  logic                                        clock,
   input  logic                                        reset_n,
   input  logic                                        start,
   input  logic [AWIDTH-1:0]                           start_addr,
   uram_line_loader_if.master                          bus,
   output logic                                        busy,
   output logic                                        done,
   output logic [AWIDTH-$clog2(LWIDTH/DWIDTH):0]       lines_written,
   output logic                                        wrapped
);
   localparam int unsigned RATIO    = LWIDTH / DWIDTH;
   localparam int unsigned SEL_BITS = $clog2(RATIO);
   localparam int unsigned DEPTH    = AWIDTH - SEL_BITS;
   localparam int unsigned LW_BITS  = DEPTH + 1;

   // Elaboration-time guard on the line/word geometry.
   if (LWIDTH <= DWIDTH || (LWIDTH % DWIDTH) != 0 || (1 << SEL_BITS) != RATIO) begin : g_bad_cfg
      $error("uram_line_loader: LWIDTH must be a power-of-two multiple of DWIDTH greater than DWIDTH");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [SEL_BITS-1:0] lane_q, lane_d;
   logic [LWIDTH-1:0]   buf_q, buf_d;
   logic [DEPTH-1:0]    ptr_q, ptr_d;
   logic [LW_BITS-1:0]  lw_q, lw_d;
   logic                wrapped_q, wrapped_d;
   logic                last_q, last_d;

   logic                s_ready_q, s_ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                mem_en_q, mem_en_d;
   logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [LWIDTH-1:0]   mem_data_q, mem_data_d;
   logic                accept;

   // Lane-select bits of start_addr are intentionally dropped.
   logic unused_sel;
   assign unused_sel = ^start_addr[SEL_BITS-1:0];

   assign accept = s_ready_q & bus.s_valid;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      buf_d     = buf_q;
      ptr_d     = ptr_q;
      lw_d      = lw_q;
      wrapped_d = wrapped_q;
      last_d    = last_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d     = start_addr[AWIDTH-1:SEL_BITS];
               lane_d    = '0;
               buf_d     = '0;
               lw_d      = '0;
               wrapped_d = 1'b0;
               last_d    = 1'b0;
               state_d   = FILL;
            end
         end
         FILL: begin
            if (accept) begin
               for (int unsigned k = 0; k < RATIO; k++) begin
                  if (lane_q == SEL_BITS'(k)) buf_d[k*DWIDTH +: DWIDTH] = bus.s_data;
               end
               lane_d = lane_q + SEL_BITS'(1);
               if (lane_q == SEL_BITS'(RATIO - 1) || bus.s_last) begin
                  last_d  = bus.s_last;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            ptr_d  = ptr_q + DEPTH'(1);
            if (&ptr_q) wrapped_d = 1'b1;
            lw_d   = lw_q + LW_BITS'(1);
            buf_d  = '0;
            lane_d = '0;
            state_d = last_q ? DONE : FILL;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs reflect the state being entered so they are valid during it.
      s_ready_d  = (state_d == FILL);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      mem_en_d   = (state_d == WRITE);
      mem_addr_d = mem_en_d ? {ptr_d, {SEL_BITS{1'b0}}} : '0;
      mem_data_d = mem_en_d ? buf_d : '0;
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         lane_q     <= '0;
         buf_q      <= '0;
         ptr_q      <= '0;
         lw_q       <= '0;
         wrapped_q  <= 1'b0;
         last_q     <= 1'b0;
         s_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mem_en_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         buf_q      <= buf_d;
         ptr_q      <= ptr_d;
         lw_q       <= lw_d;
         wrapped_q  <= wrapped_d;
         last_q     <= last_d;
         s_ready_q  <= s_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mem_en_q   <= mem_en_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
      end
   end

   assign bus.s_ready     = s_ready_q;
   assign bus.mem_en      = mem_en_q;
   assign bus.mem_wr_en   = mem_en_q;
   assign bus.mem_address = mem_addr_q;
   assign bus.mem_wr_data = mem_data_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign lines_written   = lw_q;
   assign wrapped         = wrapped_q;
endmodule

// File: tb/tb_uram_line_loader.sv
// Directed bench for uram_line_loader (DWIDTH=8, LWIDTH=32, AWIDTH=8).
module tb_uram_line_loader;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 8;
   localparam int unsigned LW = 32;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] start_addr;
   logic          busy, done, wrapped;
   logic [6:0]    lines_written;

   uram_line_loader_if #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) bus ();

   uram_line_loader #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .start_addr    (start_addr),
      .bus           (bus.master),
      .busy          (busy),
      .done          (done),
      .lines_written (lines_written),
      .wrapped       (wrapped)
   );

   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int en_bad = 0;
   int acc_cyc;
   logic [AW-1:0] wa_q[$];
   logic [LW-1:0] wd_q[$];

   always @(posedge clock) cyc <= cyc + 1;

   // Record every line write; flag any enable/write-enable disagreement.
   always @(negedge clock) begin
      if (bus.mem_wr_en === 1'b1) begin
         wa_q.push_back(bus.mem_address);
         wd_q.push_back(bus.mem_wr_data);
      end
      if (bus.mem_en !== bus.mem_wr_en) en_bad++;
   end

   task automatic send_word(input logic [7:0] d, input logic last, output bit ok);
      bit rdy;
      ok = 1'b0;
      bus.s_data  = d;
      bus.s_last  = last;
      bus.s_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         rdy = bus.s_ready;
         @(posedge clock);
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      acc_cyc     = cyc;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic pulse_start(input logic [7:0] a);
      start_addr = a;
      start      = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic run_load(input logic [7:0] a, input int n, input logic [7:0] w[8], output bit ok);
      bit o;
      ok = 1'b1;
      pulse_start(a);
      for (int i = 0; i < n; i++) begin
         send_word(w[i], (i == n - 1), o);
         ok &= o;
      end
      wait_done(o);
      ok &= o;
   endtask

   task automatic test_reset();
      logic [47:0] outs;
      reset_n = 1'b0; start = 1'b0; start_addr = '0;
      bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0;
      #2;
      outs = {busy, done, bus.s_ready, bus.mem_en, bus.mem_wr_en, wrapped, lines_written,
              bus.mem_address, bus.mem_wr_data};
      n_cmp++; if (outs !== 48'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock); #1;
      n_cmp++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL idle_s_ready: got %b want 0", bus.s_ready); end
   endtask

   task automatic test_full_line();
      bit o, ok;
      int t0;
      wa_q.delete(); wd_q.delete();
      ok = 1'b1;
      pulse_start(8'h10);
      send_word(8'h11, 1'b0, o); ok &= o; t0 = acc_cyc;
      send_word(8'h22, 1'b0, o); ok &= o;
      send_word(8'h33, 1'b0, o); ok &= o;
      send_word(8'h44, 1'b1, o); ok &= o;
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_accept: got %b want 1", ok); end
      n_cmp++; if (acc_cyc - t0 !== 3) begin n_fail++; $display("FAIL full_b2b: got %0d want 3", acc_cyc - t0); end
      @(negedge clock);
      n_cmp++; if ({bus.mem_wr_en, bus.s_ready, done} !== 3'b100) begin n_fail++; $display("FAIL full_write_cycle: got %b want 100", {bus.mem_wr_en, bus.s_ready, done}); end
      n_cmp++; if (bus.mem_address !== 8'h10) begin n_fail++; $display("FAIL full_addr: got %h want 10", bus.mem_address); end
      n_cmp++; if (bus.mem_wr_data !== 32'h44332211) begin n_fail++; $display("FAIL full_data: got %h want 44332211", bus.mem_wr_data); end
      @(negedge clock);
      n_cmp++; if ({done, bus.mem_wr_en, busy} !== 3'b101) begin n_fail++; $display("FAIL full_done_pulse: got %b want 101", {done, bus.mem_wr_en, busy}); end
      @(negedge clock);
      n_cmp++; if ({done, busy, wrapped} !== 3'b000) begin n_fail++; $display("FAIL full_idle_flags: got %b want 000", {done, busy, wrapped}); end
      n_cmp++; if (lines_written !== 7'd1) begin n_fail++; $display("FAIL full_lines: got %0d want 1", lines_written); end
      n_cmp++; if (wa_q.size() !== 1) begin n_fail++; $display("FAIL full_write_count: got %0d want 1", wa_q.size()); end
      @(posedge clock); #1;
   endtask

   task automatic test_wrap();
      bit ok;
      logic [7:0] w[8];
      w = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      wa_q.delete(); wd_q.delete();
      run_load(8'hFC, 8, w, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_handshake: got %b want 1", ok); end
      n_cmp++; if (wa_q.size() !== 2) begin n_fail++; $display("FAIL wrap_write_count: got %0d want 2", wa_q.size()); end
      else begin
         n_cmp++; if ({wa_q[0], wd_q[0]} !== {8'hFC, 32'h03020100}) begin n_fail++; $display("FAIL wrap_w0: got %h %h want fc 03020100", wa_q[0], wd_q[0]); end
         n_cmp++; if ({wa_q[1], wd_q[1]} !== {8'h00, 32'h07060504}) begin n_fail++; $display("FAIL wrap_w1: got %h %h want 00 07060504", wa_q[1], wd_q[1]); end
      end
      n_cmp++; if (wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_flag: got %b want 1", wrapped); end
      n_cmp++; if (lines_written !== 7'd2) begin n_fail++; $display("FAIL wrap_lines: got %0d want 2", lines_written); end
   endtask

   task automatic test_alignment();
      bit ok;
      logic [7:0] w[8];
      w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
      wa_q.delete(); wd_q.delete();
      run_load(8'h13, 4, w, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL align_handshake: got %b want 1", ok); end
      n_cmp++; if (wa_q.size() !== 1) begin n_fail++; $display("FAIL align_write_count: got %0d want 1", wa_q.size()); end
      else begin
         n_cmp++; if ({wa_q[0], wd_q[0]} !== {8'h10, 32'h04030201}) begin n_fail++; $display("FAIL align_w0: got %h %h want 10 04030201", wa_q[0], wd_q[0]); end
      end
      n_cmp++; if ({wrapped, lines_written} !== {1'b0, 7'd1}) begin n_fail++; $display("FAIL align_flags: got %b/%0d want 0/1", wrapped, lines_written); end
   endtask

   task automatic test_partial();
      bit ok;
      logic [7:0] w[8];
      w = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h00};
      wa_q.delete(); wd_q.delete();
      run_load(8'h00, 6, w, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL partial_handshake: got %b want 1", ok); end
      n_cmp++; if (wa_q.size() !== 2) begin n_fail++; $display("FAIL partial_write_count: got %0d want 2", wa_q.size()); end
      else begin
         n_cmp++; if ({wa_q[0], wd_q[0]} !== {8'h00, 32'hDDCCBBAA}) begin n_fail++; $display("FAIL partial_w0: got %h %h want 00 ddccbbaa", wa_q[0], wd_q[0]); end
         n_cmp++; if ({wa_q[1], wd_q[1]} !== {8'h04, 32'h0000FFEE}) begin n_fail++; $display("FAIL partial_w1: got %h %h want 04 0000ffee", wa_q[1], wd_q[1]); end
      end
      n_cmp++; if (lines_written !== 7'd2) begin n_fail++; $display("FAIL partial_lines: got %0d want 2", lines_written); end
   endtask

   task automatic test_handshake();
      bit o, ok;
      int t4;
      wa_q.delete(); wd_q.delete();
      ok = 1'b1;
      pulse_start(8'h20);
      send_word(8'h5A, 1'b0, o); ok &= o;
      @(posedge clock); #1;
      send_word(8'h6B, 1'b0, o); ok &= o;
      @(posedge clock); #1;
      send_word(8'h7C, 1'b0, o); ok &= o;
      send_word(8'h8D, 1'b0, o); ok &= o; t4 = acc_cyc;
      send_word(8'h9E, 1'b0, o); ok &= o;
      n_cmp++; if (acc_cyc - t4 !== 2) begin n_fail++; $display("FAIL hs_held_word: got %0d want 2 cycles", acc_cyc - t4); end
      pulse_start(8'h80);
      send_word(8'hAF, 1'b0, o); ok &= o;
      send_word(8'hB0, 1'b0, o); ok &= o;
      send_word(8'hC1, 1'b1, o); ok &= o;
      wait_done(o); ok &= o;
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hs_handshake: got %b want 1", ok); end
      n_cmp++; if (wa_q.size() !== 2) begin n_fail++; $display("FAIL hs_write_count: got %0d want 2", wa_q.size()); end
      else begin
         n_cmp++; if ({wa_q[0], wd_q[0]} !== {8'h20, 32'h8D7C6B5A}) begin n_fail++; $display("FAIL hs_w0: got %h %h want 20 8d7c6b5a", wa_q[0], wd_q[0]); end
         n_cmp++; if ({wa_q[1], wd_q[1]} !== {8'h24, 32'hC1B0AF9E}) begin n_fail++; $display("FAIL hs_w1: got %h %h want 24 c1b0af9e", wa_q[1], wd_q[1]); end
      end
      n_cmp++; if (lines_written !== 7'd2) begin n_fail++; $display("FAIL hs_lines: got %0d want 2", lines_written); end
   endtask

   task automatic test_reset_midload();
      bit o, ok;
      logic [47:0] outs;
      logic [7:0] w[8];
      wa_q.delete(); wd_q.delete();
      pulse_start(8'h30);
      send_word(8'h12, 1'b0, o);
      send_word(8'h34, 1'b0, o);
      reset_n = 1'b0;
      #1;
      outs = {busy, done, bus.s_ready, bus.mem_en, bus.mem_wr_en, wrapped, lines_written,
              bus.mem_address, bus.mem_wr_data};
      n_cmp++; if (outs !== 48'h0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h want 0", outs); end
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock); #1;
      n_cmp++; if (wa_q.size() !== 0) begin n_fail++; $display("FAIL rst_mid_no_write: got %0d want 0", wa_q.size()); end
      w = '{8'h56, 8'h78, 8'h9A, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load(8'h30, 4, w, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_handshake: got %b want 1", ok); end
      n_cmp++; if (wa_q.size() !== 1) begin n_fail++; $display("FAIL rst_fresh_write_count: got %0d want 1", wa_q.size()); end
      else begin
         n_cmp++; if ({wa_q[0], wd_q[0]} !== {8'h30, 32'hBC9A7856}) begin n_fail++; $display("FAIL rst_fresh_w0: got %h %h want 30 bc9a7856", wa_q[0], wd_q[0]); end
      end
      n_cmp++; if (lines_written !== 7'd1) begin n_fail++; $display("FAIL rst_fresh_lines: got %0d want 1", lines_written); end
   endtask

   initial begin
      test_reset();
      test_full_line();
      test_wrap();
      test_alignment();
      test_partial();
      test_handshake();
      test_reset_midload();
      n_cmp++; if (en_bad !== 0) begin n_fail++; $display("FAIL mem_en_vs_wr_en: got %0d disagreeing cycles want 0", en_bad); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
